machine_ctrl: RTL and testbench

- Instruction-cycle control FSM for the simple RISC CPU.
- Generates the strobes that drive the program counter (inc_pc, load_pc), the instruction register, the accumulator, memory read/write, the address mux and the data-bus driver.
- Each instruction takes an 8-state fetch/decode/execute cycle.
- inc_pc is an edge strobe: the program counter advances, or loads ir_addr when load_pc=1, on each rising edge of inc_pc.

---
 rtl/machine_ctrl_if.sv | 30 +++
 rtl/machine_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_machine_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/machine_ctrl_if.sv
// Control bus between the instruction-cycle controller and the CPU datapath.
// The master side owns run enable and the decoded instruction fields; the
// slave side (machine_ctrl) owns every datapath strobe.
interface machine_ctrl_if;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc;
    logic       load_pc;
    logic       load_acc;
    logic       rd;
    logic       wr;
    logic       ir_hi_en;
    logic       ir_lo_en;
    logic       addr_sel;
    logic       datactl_ena;
    logic       halt;

    modport master (
        output ena, opcode, zero,
        input  inc_pc, load_pc, load_acc, rd, wr, ir_hi_en, ir_lo_en,
               addr_sel, datactl_ena, halt
    );

    modport slave (
        input  ena, opcode, zero,
        output inc_pc, load_pc, load_acc, rd, wr, ir_hi_en, ir_lo_en,
               addr_sel, datactl_ena, halt
    );
endinterface

// File: rtl/machine_ctrl.sv
// Instruction-cycle control FSM for the simple RISC CPU.
// Every instruction walks an 8-state fetch/decode/execute cycle (S0..S7).
// All strobes are registered from the next-state decode, so the strobe set
// belonging to a state is present for the whole cycle the FSM sits in it and
// inc_pc is glitch-free (the PC is clocked by its rising edge).
module machine_ctrl #(
    parameter bit HALT_RESUME = 1'b0   // 1: HALT returns to IDLE when ena drops
) (
    input  logic          clk,
    input  logic          rst_n,
    machine_ctrl_if.slave bus
);

    // State encoding (kept as plain constants for legacy tooling)
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_S0   = 4'd1;
    localparam logic [3:0] ST_S1   = 4'd2;
    localparam logic [3:0] ST_S2   = 4'd3;
    localparam logic [3:0] ST_S3   = 4'd4;
    localparam logic [3:0] ST_S4   = 4'd5;
    localparam logic [3:0] ST_S5   = 4'd6;
    localparam logic [3:0] ST_S6   = 4'd7;
    localparam logic [3:0] ST_S7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    // Opcodes (IR[15:13])
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       r_skz_flag;
    logic       w_is_alu;

    logic w_inc_pc, w_load_pc, w_load_acc, w_rd, w_wr;
    logic w_ir_hi_en, w_ir_lo_en, w_addr_sel, w_datactl_ena, w_halt;
    logic r_inc_pc, r_load_pc, r_load_acc, r_rd, r_wr;
    logic r_ir_hi_en, r_ir_lo_en, r_addr_sel, r_datactl_ena, r_halt;

    // ALU group: instructions that read an operand and load the accumulator
    always_comb begin
        w_is_alu = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_AND, OP_XOR, OP_LDA: w_is_alu = 1'b1;
            default:                        w_is_alu = 1'b0;
        endcase
    end

    // Next-state logic for the instruction cycle
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (bus.ena) w_next_state = ST_S0;
                else         w_next_state = ST_IDLE;
            end
            ST_S0: w_next_state = ST_S1;
            ST_S1: w_next_state = ST_S2;
            ST_S2: w_next_state = ST_S3;
            ST_S3: begin
                if (bus.opcode == OP_HLT) w_next_state = ST_HALT;
                else                      w_next_state = ST_S4;
            end
            ST_S4: w_next_state = ST_S5;
            ST_S5: w_next_state = ST_S6;
            ST_S6: w_next_state = ST_S7;
            ST_S7: begin
                if (bus.ena) w_next_state = ST_S0;
                else         w_next_state = ST_IDLE;
            end
            ST_HALT: begin
                if (HALT_RESUME && !bus.ena) w_next_state = ST_IDLE;
                else                         w_next_state = ST_HALT;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Strobe decode for the state being entered on the next edge
    always_comb begin
        w_inc_pc      = 1'b0;
        w_load_pc     = 1'b0;
        w_load_acc    = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_ir_hi_en    = 1'b0;
        w_ir_lo_en    = 1'b0;
        w_addr_sel    = 1'b0;
        w_datactl_ena = 1'b0;
        w_halt        = 1'b0;
        case (w_next_state)
            ST_S0: begin
                w_rd       = 1'b1;
                w_ir_hi_en = 1'b1;
            end
            ST_S1: begin
                w_inc_pc   = 1'b1;
                w_rd       = 1'b1;
                w_ir_lo_en = 1'b1;
            end
            ST_S3: begin
                w_inc_pc = 1'b1;
                w_halt   = (bus.opcode == OP_HLT);
            end
            ST_S4: begin
                if (w_is_alu) begin
                    w_addr_sel = 1'b1;
                    w_rd       = 1'b1;
                end else if (bus.opcode == OP_STO) begin
                    w_addr_sel    = 1'b1;
                    w_datactl_ena = 1'b1;
                end else if (bus.opcode == OP_JMP) begin
                    // inc_pc stays low here so S5 gives a clean load edge
                    w_load_pc = 1'b1;
                end else begin
                    w_load_pc = 1'b0;
                end
            end
            ST_S5: begin
                if (w_is_alu) begin
                    w_addr_sel = 1'b1;
                    w_rd       = 1'b1;
                    w_load_acc = 1'b1;
                end else if (bus.opcode == OP_STO) begin
                    w_addr_sel    = 1'b1;
                    w_datactl_ena = 1'b1;
                    w_wr          = 1'b1;
                end else if (bus.opcode == OP_JMP) begin
                    w_load_pc = 1'b1;
                    w_inc_pc  = 1'b1;
                end else if (bus.opcode == OP_SKZ) begin
                    w_inc_pc = r_skz_flag;
                end else begin
                    w_inc_pc = 1'b0;
                end
            end
            ST_S6: begin
                if (bus.opcode == OP_STO) begin
                    w_addr_sel    = 1'b1;
                    w_datactl_ena = 1'b1;
                end else begin
                    w_addr_sel = 1'b0;
                end
            end
            ST_S7: begin
                // second half of the skip: two PC edges in total
                if (bus.opcode == OP_SKZ) w_inc_pc = r_skz_flag;
                else                      w_inc_pc = 1'b0;
            end
            ST_HALT: w_halt = 1'b1;
            default: w_halt = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Capture the zero flag on entry to S4 so the skip decision is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_skz_flag <= 1'b0;
        else if (w_next_state == ST_S4) r_skz_flag <= bus.zero;
        else                            r_skz_flag <= r_skz_flag;
    end

    // Registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc_pc      <= 1'b0;
            r_load_pc     <= 1'b0;
            r_load_acc    <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_ir_hi_en    <= 1'b0;
            r_ir_lo_en    <= 1'b0;
            r_addr_sel    <= 1'b0;
            r_datactl_ena <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            r_inc_pc      <= w_inc_pc;
            r_load_pc     <= w_load_pc;
            r_load_acc    <= w_load_acc;
            r_rd          <= w_rd;
            r_wr          <= w_wr;
            r_ir_hi_en    <= w_ir_hi_en;
            r_ir_lo_en    <= w_ir_lo_en;
            r_addr_sel    <= w_addr_sel;
            r_datactl_ena <= w_datactl_ena;
            r_halt        <= w_halt;
        end
    end

    assign bus.inc_pc      = r_inc_pc;
    assign bus.load_pc     = r_load_pc;
    assign bus.load_acc    = r_load_acc;
    assign bus.rd          = r_rd;
    assign bus.wr          = r_wr;
    assign bus.ir_hi_en    = r_ir_hi_en;
    assign bus.ir_lo_en    = r_ir_lo_en;
    assign bus.addr_sel    = r_addr_sel;
    assign bus.datactl_ena = r_datactl_ena;
    assign bus.halt        = r_halt;

endmodule

// File: tb/tb_machine_ctrl.sv
// Self-checking bench for machine_ctrl: per-opcode strobe tables, hand-written
// reset/halt/ena-drop sequences, and random programs checked against a PC
// movement model plus rule-level invariants.
module tb_machine_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    machine_ctrl_if bus ();

    machine_ctrl #(.HALT_RESUME(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // output vector bit masks
    localparam logic [9:0] INC  = 10'h001;
    localparam logic [9:0] LPC  = 10'h002;
    localparam logic [9:0] LACC = 10'h004;
    localparam logic [9:0] RD   = 10'h008;
    localparam logic [9:0] WR   = 10'h010;
    localparam logic [9:0] IRH  = 10'h020;
    localparam logic [9:0] IRL  = 10'h040;
    localparam logic [9:0] ASEL = 10'h080;
    localparam logic [9:0] DCTL = 10'h100;
    localparam logic [9:0] HLTB = 10'h200;
    localparam logic [9:0] NONE = 10'h000;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic        z;
        logic [79:0] expv;   // {S7,...,S0}, 10 bits each
        string       name;
    } vec_t;

    vec_t tbl[8];

    int checks = 0;
    int errors = 0;

    // simulated program counter clocked by the controller's strobe
    logic [7:0]  ir_addr = 8'd0;
    logic [7:0]  pc_hw   = 8'd0;
    int unsigned edges   = 0;

    always @(posedge bus.inc_pc) begin
        edges <= edges + 1;
        if (bus.load_pc) pc_hw <= ir_addr;
        else             pc_hw <= pc_hw + 8'd1;
    end

    function automatic logic [9:0] outs();
        return {bus.halt, bus.datactl_ena, bus.addr_sel, bus.ir_lo_en, bus.ir_hi_en,
                bus.wr, bus.rd, bus.load_acc, bus.load_pc, bus.inc_pc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_alu(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    endfunction

    // Runs one instruction S0..S7; next edge must enter S0.
    task automatic run_instr(input logic [2:0] op, input logic z, input logic [7:0] tgt,
                             input bit cmp, input logic [79:0] expv, input int drop_at,
                             input string tag);
        logic [7:0]  pc0;
        int unsigned e0;
        int          n_lacc;
        int          n_wr;
        logic [9:0]  o;
        logic [7:0]  pc_exp;
        int          e_exp;
        pc0    = pc_hw;
        e0     = edges;
        n_lacc = 0;
        n_wr   = 0;
        bus.opcode = 3'($urandom);
        for (int p = 0; p < 8; p++) begin
            tick();
            o = outs();
            if (cmp) chk($sformatf("%s_S%0d", tag, p), 32'(o), 32'(expv[p*10 +: 10]));
            chk($sformatf("%s_rdwr_S%0d", tag, p), 32'(bus.rd & bus.wr), 32'd0);
            chk($sformatf("%s_frame_S%0d", tag, p), 32'(bus.ir_hi_en), 32'(p == 0));
            if (p >= 2) chk($sformatf("%s_lpc_S%0d", tag, p), 32'(bus.load_pc & (op != OP_JMP)), 32'd0);
            if (bus.load_acc) n_lacc++;
            if (bus.wr) n_wr++;
            if (p == 0) ir_addr = tgt;
            if (p == 1) bus.opcode = op;
            if (p == 3) bus.zero = z;
            else if (p == 4) bus.zero = ~z;
            else bus.zero = 1'($urandom);
            if (p == drop_at) bus.ena = 1'b0;
        end
        // PC model: each instruction moves 2 bytes, a taken skip 4, a jump loads its target
        if (op == OP_JMP) begin
            pc_exp = tgt;
            e_exp  = 3;
        end else if (op == OP_SKZ && z) begin
            pc_exp = pc0 + 8'd4;
            e_exp  = 4;
        end else begin
            pc_exp = pc0 + 8'd2;
            e_exp  = 2;
        end
        chk({tag, "_pc"}, 32'(pc_hw), 32'(pc_exp));
        chk({tag, "_edges"}, edges - e0, 32'(e_exp));
        chk({tag, "_lacc_cnt"}, 32'(n_lacc), 32'(is_alu(op) ? 1 : 0));
        chk({tag, "_wr_cnt"}, 32'(n_wr), 32'(op == OP_STO ? 1 : 0));
    endtask

    localparam logic [9:0] S0V = RD | IRH;
    localparam logic [9:0] S1V = INC | RD | IRL;
    localparam logic [9:0] S3V = INC;

    initial begin
        logic [2:0]  rop;
        int          drop;
        int unsigned e_hold;
        logic [7:0]  pc_hold;

        tbl[0] = '{3'b010, 1'b0, {NONE, NONE, ASEL|RD|LACC, ASEL|RD, S3V, NONE, S1V, S0V}, "ADD"};
        tbl[1] = '{3'b011, 1'b1, {NONE, NONE, ASEL|RD|LACC, ASEL|RD, S3V, NONE, S1V, S0V}, "AND"};
        tbl[2] = '{3'b100, 1'b0, {NONE, NONE, ASEL|RD|LACC, ASEL|RD, S3V, NONE, S1V, S0V}, "XOR"};
        tbl[3] = '{3'b101, 1'b1, {NONE, NONE, ASEL|RD|LACC, ASEL|RD, S3V, NONE, S1V, S0V}, "LDA"};
        tbl[4] = '{3'b110, 1'b1, {NONE, ASEL|DCTL, ASEL|DCTL|WR, ASEL|DCTL, S3V, NONE, S1V, S0V}, "STO"};
        tbl[5] = '{3'b111, 1'b0, {NONE, NONE, LPC|INC, LPC, S3V, NONE, S1V, S0V}, "JMP"};
        tbl[6] = '{3'b001, 1'b1, {INC, NONE, INC, NONE, S3V, NONE, S1V, S0V}, "SKZ1"};
        tbl[7] = '{3'b001, 1'b0, {NONE, NONE, NONE, NONE, S3V, NONE, S1V, S0V}, "SKZ0"};

        // reset state
        bus.ena = 1'b0; bus.opcode = 3'b000; bus.zero = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(); chk("idle_outs0", 32'(outs()), 32'd0);
        tick(); chk("idle_outs1", 32'(outs()), 32'd0);
        bus.ena = 1'b1;

        // per-opcode strobe tables, back to back
        for (int i = 0; i < 8; i++)
            run_instr(tbl[i].op, tbl[i].z, 8'h40 + 8'(i), 1'b1, tbl[i].expv, -1, tbl[i].name);

        // ena dropped during S2 of an ADD: finish, then park in IDLE
        run_instr(tbl[0].op, 1'b0, 8'h00, 1'b1, tbl[0].expv, 2, "ADD_drop");
        for (int k = 0; k < 3; k++) begin
            tick(); chk($sformatf("park_idle%0d", k), 32'(outs()), 32'd0);
        end
        bus.ena = 1'b1;

        // reset during S5 of a STO
        e_hold = edges;
        bus.opcode = 3'b000;
        for (int p = 0; p < 6; p++) begin
            tick();
            chk($sformatf("STO_rst_S%0d", p), 32'(outs()), 32'(tbl[4].expv[p*10 +: 10]));
            if (p == 1) bus.opcode = OP_STO;
        end
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", 32'(outs()), 32'd0);
        tick(); chk("reset_hold_outs", 32'(outs()), 32'd0);
        chk("reset_edges", edges - e_hold, 32'd2);
        @(negedge clk) rst_n = 1'b1;
        run_instr(tbl[0].op, 1'b0, 8'h00, 1'b1, tbl[0].expv, -1, "ADD_after_rst");

        // HLT: halt from S3, held with no strobes, resume via ena
        e_hold  = edges;
        pc_hold = pc_hw;
        bus.opcode = 3'b101;
        for (int p = 0; p < 4; p++) begin
            tick();
            chk($sformatf("HLT_S%0d", p), 32'(outs()),
                32'(p == 0 ? S0V : p == 1 ? S1V : p == 2 ? NONE : (S3V | HLTB)));
            if (p == 1) bus.opcode = OP_HLT;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.zero = 1'($urandom);
            chk($sformatf("halt_hold%0d", k), 32'(outs()), 32'(HLTB));
        end
        chk("halt_edges", edges - e_hold, 32'd2);
        chk("halt_pc", 32'(pc_hw), 32'(pc_hold + 8'd2));
        bus.ena = 1'b0;
        tick(); chk("halt_resume_idle", 32'(outs()), 32'd0);
        tick(); chk("halt_resume_idle2", 32'(outs()), 32'd0);
        bus.ena = 1'b1;

        // random programs against the PC model and rule invariants
        for (int n = 0; n < 150; n++) begin
            rop  = 3'($urandom_range(7, 1));
            drop = ($urandom_range(7, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            run_instr(rop, 1'($urandom), 8'($urandom), 1'b0, 80'd0, drop,
                      $sformatf("rnd%0d", n));
            if (drop >= 0) begin
                tick(); chk($sformatf("rnd%0d_idle", n), 32'(outs()), 32'd0);
                bus.ena = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
